// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 32;
  localparam int PC_STEP     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/ifetch_queue.sv
// Two-entry {instr, pc} FIFO with registered head and synchronous flush.
// The head registers keep their last contents when the queue empties.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [INSTR_W-1:0] i_push_instr,
  input  logic [PC_W-1:0]    i_push_pc,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [1:0]         o_count,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_head_instr,
  output logic [PC_W-1:0]    o_head_pc
);

  logic [1:0]         r_count;
  logic               r_valid;
  logic [INSTR_W-1:0] r_head_instr;
  logic [PC_W-1:0]    r_head_pc;
  logic [INSTR_W-1:0] r_tail_instr;
  logic [PC_W-1:0]    r_tail_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= 2'd0;
      r_valid      <= 1'b0;
      r_head_instr <= '0;
      r_head_pc    <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_instr <= i_push_instr;
            r_head_pc    <= i_push_pc;
            r_count      <= 2'd1;
            r_valid      <= 1'b1;
          end else if (r_count == 2'd1) begin
            r_tail_instr <= i_push_instr;
            r_tail_pc    <= i_push_pc;
            r_count      <= 2'd2;
          end
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
            r_count      <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_count <= 2'd0;
            r_valid <= 1'b0;
          end
        end
        2'b11: begin
          // Occupancy unchanged: the tail (or the new word) moves up to the head.
          if (r_count == 2'd2) begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
            r_tail_instr <= i_push_instr;
            r_tail_pc    <= i_push_pc;
          end else if (r_count == 2'd1) begin
            r_head_instr <= i_push_instr;
            r_head_pc    <= i_push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_valid      = r_valid;
  assign o_head_instr = r_head_instr;
  assign o_head_pc    = r_head_pc;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: IDLE/RUN/HALT FSM, program counter and redirect handling.
// Optional misaligned-redirect trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ins_valid,
  input  logic               ins_ready,
  output logic [INSTR_W-1:0] ins_data,
  output logic [PC_W-1:0]    ins_pc,
  output logic               busy,
  output logic               misalign_err
);

  state_t          r_state;
  logic            r_busy;
  logic [PC_W-1:0] r_fetch_pc;

  logic [1:0]      w_count;
  logic            w_pop;
  logic            w_push;
  logic [PC_W-1:0] w_redirect_pc;

  assign w_pop         = ins_valid & ins_ready;
  assign w_push        = (r_state == ST_RUN) & ~redirect_valid & ~halt_req &
                         ((w_count != 2'd2) | w_pop);
  assign w_redirect_pc = redirect_pc & ~PC_W'(3);

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misalign;
  assign w_misalign   = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign misalign_err = r_misalign;
`else
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_fetch_pc <= RESET_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      if (redirect_valid)
        r_fetch_pc <= w_redirect_pc;
      else if (w_push)
        r_fetch_pc <= r_fetch_pc + PC_W'(PC_STEP);

      case (r_state)
        ST_RUN: begin
          if (halt_req) begin
            r_state <= ST_HALT;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE, ST_HALT: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
`ifdef IFETCH_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

`ifdef IFETCH_MISALIGN_TRAP_EN
      // A trap outranks any start seen in the same cycle.
      if (w_misalign) begin
        r_misalign <= 1'b1;
        r_state    <= ST_HALT;
        r_busy     <= 1'b0;
      end
`endif
    end
  end

  ifetch_queue #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_instr (imem_instr),
    .i_push_pc    (r_fetch_pc),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .o_count      (w_count),
    .o_valid      (ins_valid),
    .o_head_instr (ins_data),
    .o_head_pc    (ins_pc)
  );

  assign imem_pc = r_fetch_pc;
  assign busy    = r_busy;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl; a second instance covers the PC wrap from 8'hF8.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        ins_ready = 1'b0;
  logic [7:0]  imem_pc;
  logic [31:0] imem_instr;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [7:0]  ins_pc;
  logic        busy;
  logic        misalign_err;

  logic        start2 = 1'b0;
  logic        halt2 = 1'b0;
  logic [7:0]  imem_pc2;
  logic [31:0] imem_instr2;
  logic        ins_valid2;
  logic [31:0] ins_data2;
  logic [7:0]  ins_pc2;
  logic        busy2;
  logic        misalign_err2;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {2'b10, a[7:2], 8'hC3, ~a[7:2], 2'b01, a[7:2] ^ 6'h15, 2'b11};
  endfunction

  assign imem_instr  = mem_word(imem_pc);
  assign imem_instr2 = mem_word(imem_pc2);

  ifetch_ctrl #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
    .ins_pc(ins_pc), .busy(busy), .misalign_err(misalign_err)
  );

  ifetch_ctrl #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'hF8)) u_dut_wrap (
    .clk(clk), .rst(rst), .start(start2), .halt_req(halt2),
    .imem_pc(imem_pc2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_pc(8'h00),
    .ins_valid(ins_valid2), .ins_ready(1'b1), .ins_data(ins_data2),
    .ins_pc(ins_pc2), .busy(busy2), .misalign_err(misalign_err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Handshakes are sampled mid-cycle; they complete on the following rising edge.
  always @(negedge clk) begin
    if (!rst && ins_valid && ins_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", {24'h0, ins_pc}, 32'hFFFF_FFFF);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("ins_pc", {24'h0, ins_pc}, {24'h0, e});
        chk("ins_data", ins_data, mem_word(e));
      end
    end
    if (!rst && ins_valid2) begin
      if (exp2_q.size() == 0) chk("wrap_underflow", {24'h0, ins_pc2}, 32'hFFFF_FFFF);
      else begin
        logic [7:0] e;
        e = exp2_q.pop_front();
        chk("wrap_ins_pc", {24'h0, ins_pc2}, {24'h0, e});
        chk("wrap_ins_data", ins_data2, mem_word(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    ins_ready = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_valid", {31'h0, ins_valid}, 32'h0);
    chk("rst_data", ins_data, 32'h0);
    chk("rst_pc", {24'h0, ins_pc}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
    chk("rst_imem_pc", {24'h0, imem_pc}, 32'h0);
    chk("rst_wrap_imem_pc", {24'h0, imem_pc2}, 32'hF8);
    step(1);
    chk("idle_valid", {31'h0, ins_valid}, 32'h0);

    // Streaming from reset, plus the wrapping instance
    start = 1'b1;
    start2 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(8'(4 * k));
      exp2_q.push_back(8'(8'hF8 + 4 * k));
    end
    step(1);
    start = 1'b0;
    start2 = 1'b0;
    chk("start_busy", {31'h0, busy}, 32'h1);
    chk("start_valid_e0", {31'h0, ins_valid}, 32'h0);
    chk("start_imem_pc", {24'h0, imem_pc}, 32'h0);
    step(1);
    chk("start_valid_e1", {31'h0, ins_valid}, 32'h1);
    chk("start_ins_pc", {24'h0, ins_pc}, 32'h0);
    chk("stream_imem_pc", {24'h0, imem_pc}, 32'h04);
    step(8);
    halt_req = 1'b1;
    halt2 = 1'b1;
    step(1);
    halt_req = 1'b0;
    halt2 = 1'b0;
    chk("halt_busy", {31'h0, busy}, 32'h0);
    chk("halt_valid", {31'h0, ins_valid}, 32'h0);
    chk("halt_imem_pc", {24'h0, imem_pc}, 32'h24);
    step(3);
    chk("halt_imem_hold", {24'h0, imem_pc}, 32'h24);
    chk("stream_drained", 32'(exp_q.size()), 32'h0);
    chk("wrap_drained", 32'(exp2_q.size()), 32'h0);
    chk("wrap_busy", {31'h0, busy2}, 32'h0);

    // Backpressure from reset, then redirect with a full queue
    rst = 1'b1;
    exp_q.delete();
    step(1);
    rst = 1'b0;
    ins_ready = 1'b0;
    start = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h08);
    step(1);
    start = 1'b0;
    step(2);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("full_imem_pc", {24'h0, imem_pc}, 32'h08);
      chk("full_head_pc", {24'h0, ins_pc}, 32'h00);
    end
    ins_ready = 1'b1;
    step(1);
    chk("release_head_pc", {24'h0, ins_pc}, 32'h04);
    chk("release_imem_pc", {24'h0, imem_pc}, 32'h0C);
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    step(1);
    redirect_valid = 1'b0;
    chk("flush_pending", 32'(exp_q.size()), 32'h1);
    exp_q.delete();
    exp_q.push_back(8'h40);
    chk("redir_valid_r0", {31'h0, ins_valid}, 32'h0);
    chk("redir_imem_pc", {24'h0, imem_pc}, 32'h40);
    step(1);
    chk("redir_valid_r1", {31'h0, ins_valid}, 32'h1);
    chk("redir_ins_pc", {24'h0, ins_pc}, 32'h40);
    halt_req = 1'b1;
    step(1);
    halt_req = 1'b0;
    chk("halt2_busy", {31'h0, busy}, 32'h0);
    chk("halt2_imem_pc", {24'h0, imem_pc}, 32'h44);
    step(3);
    chk("halt2_imem_hold", {24'h0, imem_pc}, 32'h44);
    chk("redir_drained", 32'(exp_q.size()), 32'h0);

    // Resume at the held PC, then misaligned redirect
    start = 1'b1;
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h48);
    step(1);
    start = 1'b0;
    chk("resume_busy", {31'h0, busy}, 32'h1);
    step(2);
    redirect_valid = 1'b1;
    redirect_pc = 8'h42;
    step(1);
    redirect_valid = 1'b0;
    chk("resume_drained", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    chk("mis_valid", {31'h0, ins_valid}, 32'h0);
    chk("mis_imem_pc", {24'h0, imem_pc}, 32'h40);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("mis_err", {31'h0, misalign_err}, 32'h1);
    chk("mis_busy", {31'h0, busy}, 32'h0);
    step(2);
    chk("mis_hold_pc", {24'h0, imem_pc}, 32'h40);
    chk("mis_hold_valid", {31'h0, ins_valid}, 32'h0);
    chk("mis_err_sticky", {31'h0, misalign_err}, 32'h1);
    start = 1'b1;
    exp_q.push_back(8'h40);
    step(1);
    start = 1'b0;
    chk("mis_err_clear", {31'h0, misalign_err}, 32'h0);
    chk("mis_restart_busy", {31'h0, busy}, 32'h1);
    step(1);
`else
    chk("mis_err", {31'h0, misalign_err}, 32'h0);
    chk("mis_busy", {31'h0, busy}, 32'h1);
    exp_q.push_back(8'h40);
    step(1);
`endif
    chk("mis_fetch_valid", {31'h0, ins_valid}, 32'h1);
    chk("mis_fetch_pc", {24'h0, ins_pc}, 32'h40);
    halt_req = 1'b1;
    step(1);
    halt_req = 1'b0;
    step(2);
    chk("mis_drained", 32'(exp_q.size()), 32'h0);
    chk("final_busy", {31'h0, busy}, 32'h0);
    chk("final_misalign", {31'h0, misalign_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
